reaction_timer: RTL

- Consumes the 1 ms square wave `clk_ms` from the clock divider and implements a reaction-time measurement.
- After `start`, it waits a pseudo-random delay, lights `led`, then counts milliseconds in 4-digit BCD until `stop`.
- It holds the result and keeps the best (lowest) time.
- Runs entirely on the system clock; `clk_ms` is treated as data, never as a clock.

---
 rtl/reaction_timer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer
// Purpose  : Reaction-time game core. After a start request it waits a
//            pseudo-random number of milliseconds, lights the LED, then counts
//            milliseconds in 4-digit BCD until the player presses stop. The
//            result is held, and the best (lowest) valid time is kept. A stop
//            before the LED lights is reported as a false start.
// Ports    : clock        - system clock, all logic on its rising edge
//            reset        - asynchronous active-low reset
//            clk_ms       - 1 ms square wave, sampled as data (synchronized)
//            start        - debounced level, rising edge requests a trial
//            stop         - debounced level, rising edge is the response
//            led          - high while waiting for the player's response
//            time_bcd     - current/last reaction time, 4 BCD digits
//            best_bcd     - best valid time since reset (9999 when none)
//            false_start  - high after a stop during the pre-LED delay
//            busy         - high while a trial is in progress
// Revision : 1.0 - initial release
// ============================================================================
module reaction_timer #(
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned RAND_MASK    = 1023,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clk_ms,
   input  logic        start,
   input  logic        stop,
   output logic        led,
   output logic [15:0] time_bcd,
   output logic [15:0] best_bcd,
   output logic        false_start,
   output logic        busy
);

   localparam logic [15:0] c_min_delay = MIN_DELAY_MS[15:0];
   localparam logic [15:0] c_rand_mask = RAND_MASK[15:0];
   localparam logic [15:0] c_bcd_max   = 16'h9999;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_ARMED = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_ms_sync1;
   logic        r_ms_sync2;
   logic        r_ms_prev;
   logic        r_ms_tick;
   logic        r_start_q;
   logic        r_start_prev;
   logic        r_stop_q;
   logic        r_stop_prev;
   logic [15:0] r_lfsr;
   logic [15:0] r_delay_cnt;
   logic [15:0] r_time_bcd;
   logic [15:0] r_best_bcd;

   logic        w_start_edge;
   logic        w_stop_edge;
   logic        w_lfsr_fb;
   logic        w_load;
   logic        w_decrement;
   logic        w_count;
   logic        w_best_update;
   logic [15:0] w_time_inc;
   logic [15:0] w_time_final;

   // Saturating 4-digit BCD increment: 9999 stays 9999.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      if (v == c_bcd_max) begin
         r = v;
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Input conditioning: clk_ms is asynchronous, so it gets two flops before
   // its edge is detected; the tick itself is registered. start/stop are
   // already debounced and only need a register plus edge detect.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ms_sync1   <= 1'b0;
         r_ms_sync2   <= 1'b0;
         r_ms_prev    <= 1'b0;
         r_ms_tick    <= 1'b0;
         r_start_q    <= 1'b0;
         r_start_prev <= 1'b0;
         r_stop_q     <= 1'b0;
         r_stop_prev  <= 1'b0;
      end else begin
         r_ms_sync1   <= clk_ms;
         r_ms_sync2   <= r_ms_sync1;
         r_ms_prev    <= r_ms_sync2;
         r_ms_tick    <= r_ms_sync2 & ~r_ms_prev;
         r_start_q    <= start;
         r_start_prev <= r_start_q;
         r_stop_q     <= stop;
         r_stop_prev  <= r_stop_q;
      end
   end

   assign w_start_edge = r_start_q & ~r_start_prev;
   assign w_stop_edge  = r_stop_q  & ~r_stop_prev;

   // ------------------------------------------------------------------------
   // Free-running Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
   // ------------------------------------------------------------------------
   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      end
   end

   // ------------------------------------------------------------------------
   // State machine: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // State machine: next state and datapath controls
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_load        = 1'b0;
      w_decrement   = 1'b0;
      w_count       = 1'b0;
      w_best_update = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_FAULT: begin
            // start wins over a simultaneous stop here
            if (w_start_edge) begin
               w_state_next = S_WAIT;
               w_load       = 1'b1;
            end
         end
         S_WAIT: begin
            if (w_stop_edge) begin
               w_state_next = S_FAULT;
            end else if (r_ms_tick) begin
               // A zero count (MIN_DELAY_MS = 0 with a zero random part) arms
               // on the first tick instead of wrapping the counter.
               if (r_delay_cnt <= 16'd1) begin
                  w_state_next = S_ARMED;
               end else begin
                  w_decrement = 1'b1;
               end
            end
         end
         S_ARMED: begin
            w_count = r_ms_tick;
            if (w_stop_edge) begin
               w_state_next  = S_DONE;
               w_best_update = 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // A tick coinciding with stop is counted before the result is final.
   assign w_time_inc   = bcd_inc(r_time_bcd);
   assign w_time_final = w_count ? w_time_inc : r_time_bcd;

   // ------------------------------------------------------------------------
   // Datapath: delay counter, reaction time, best time
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_delay_cnt <= 16'd0;
         r_time_bcd  <= 16'h0000;
         r_best_bcd  <= c_bcd_max;
      end else begin
         if (w_load) begin
            r_delay_cnt <= c_min_delay + (r_lfsr & c_rand_mask);
         end else if (w_decrement) begin
            r_delay_cnt <= r_delay_cnt - 16'd1;
         end

         if (w_load) begin
            r_time_bcd <= 16'h0000;
         end else if (w_count) begin
            r_time_bcd <= w_time_inc;
         end

         // Packed BCD orders the same way as its binary value.
         if (w_best_update && (w_time_final < r_best_bcd)) begin
            r_best_bcd <= w_time_final;
         end
      end
   end

   // Outputs come straight from registers / state decode.
   assign led         = (r_state == S_ARMED);
   assign busy        = (r_state == S_WAIT) || (r_state == S_ARMED);
   assign false_start = (r_state == S_FAULT);
   assign time_bcd    = r_time_bcd;
   assign best_bcd    = r_best_bcd;

endmodule
`default_nettype wire
